// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : shift_pkg
//  Description : Shared types and the single-step shift function for the
//                shift sequencer. The same function drives the RTL datapath
//                and any reference model, so both use one definition of a
//                one-bit step.
//  Contents    : shift_state_t - FSM state encoding (IDLE, SHIFT, DONE)
//                DIR_RIGHT / DIR_LEFT - direction encodings of in_dir
//                MAX_W        - widest operand shift1 supports
//                shift1()     - one-bit left / logical-right / arith-right
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shift_state_t;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Operands are zero-extended to MAX_W bits; callers truncate the result
   // back to their own width.
   localparam int MAX_W = 64;

   // One-bit shift of the low 'width' bits of w. For right shifts the vacated
   // top bit (index width-1) takes the operand MSB when arith is set, else 0.
   // arith has no effect on left shifts.
   function automatic logic [MAX_W-1:0] shift1(
      input logic [MAX_W-1:0] w,
      input logic             dir,
      input logic             arith,
      input int               width
   );
      logic [MAX_W-1:0] r;
      if (dir == DIR_LEFT) begin
         r = w << 1;
      end else begin
         r = w >> 1;
         for (int i = 0; i < MAX_W; i++) begin
            if (i == width - 1) r[i] = arith & w[i];
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq
//  Description : Multi-cycle shift sequencer. Accepts an operand and amount
//                over a valid/ready handshake, shifts one bit per clock
//                (left, logical right or arithmetic right) and presents the
//                result over a second valid/ready handshake.
//  Ports       : clk, rst (sync, active-low)
//                in_valid/in_ready, in_d[n], in_amt[amt_n], in_dir, in_arith
//                out_valid/out_ready, out_q[n]
//                busy - high whenever the FSM is not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_seq
   import shift_pkg::*;
#(
   parameter int n     = 8,           // power of two, 2..MAX_W
   parameter int amt_n = $clog2(n)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [n-1:0]     in_d,
   input  logic [amt_n-1:0] in_amt,
   input  logic             in_dir,
   input  logic             in_arith,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [n-1:0]     out_q,
   output logic             busy
);

   shift_state_t     state, state_nx;
   logic [n-1:0]     w;
   logic [n-1:0]     w_step;
   logic [n-1:0]     q;
   logic [amt_n-1:0] cnt;
   logic             dir;
   logic             arith;
   logic             accept;
   logic             last_step;

   assign w_step    = n'(shift1(MAX_W'(w), dir, arith, n));
   assign accept    = in_valid && in_ready;
   assign last_step = (cnt == amt_n'(1));

   // in_ready is held low throughout reset so nothing is accepted before the
   // sequencer is out of reset.
   assign in_ready  = rst && (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_q     = q;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (in_amt == '0) ? DONE : SHIFT;
         SHIFT:   if (last_step) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath. q is loaded only on the edge that enters DONE, so the result
   // stays stable while it waits for the consumer and across the next request.
   always_ff @(posedge clk) begin
      if (!rst) begin
         w     <= '0;
         cnt   <= '0;
         dir   <= DIR_RIGHT;
         arith <= 1'b0;
         q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  w     <= in_d;
                  cnt   <= in_amt;
                  dir   <= in_dir;
                  arith <= in_arith;
                  if (in_amt == '0) q <= in_d;
               end
            end
            SHIFT: begin
               w   <= w_step;
               cnt <= cnt - amt_n'(1);
               if (last_step) q <= w_step;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq
//  Description : Directed self-checking bench for shift_seq (n = 8). Inputs
//                change 1 ns after a rising edge; outputs are sampled at the
//                same point, i.e. they reflect the state after that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_d;
   logic [2:0] in_amt;
   logic       in_dir;
   logic       in_arith;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_q;
   logic       busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   shift_seq #(.n(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_d      (in_d),
      .in_amt    (in_amt),
      .in_dir    (in_dir),
      .in_arith  (in_arith),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_q     (out_q),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, check busy/out_valid through every SHIFT cycle, check
   // the result in the first DONE cycle, then complete the output handshake.
   task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] amt,
                         input logic dr, input logic ar, input logic [7:0] exp_q);
      in_valid = 1'b1;
      in_d     = d;
      in_amt   = amt;
      in_dir   = dr;
      in_arith = ar;
      step();                       // accept edge t
      in_valid = 1'b0;
      for (int j = 1; j <= int'(amt); j++) begin
         chk({tag, "_shift_busy"},  32'(busy),      32'h1);
         chk({tag, "_shift_noval"}, 32'(out_valid), 32'h0);
         step();
      end
      chk({tag, "_valid"},   32'(out_valid), 32'h1);
      chk({tag, "_q"},       32'(out_q),     32'(exp_q));
      chk({tag, "_inready"}, 32'(in_ready),  32'h0);
      out_ready = 1'b1;
      step();                       // handshake edge
      out_ready = 1'b0;
      chk({tag, "_idle_inready"}, 32'(in_ready),  32'h1);
      chk({tag, "_idle_valid"},   32'(out_valid), 32'h0);
   endtask

   initial begin
      int seen_valid;
      rst       = 1'b0;
      in_valid  = 1'b1;
      in_d      = 8'hAA;
      in_amt    = 3'd1;
      in_dir    = 1'b0;
      in_arith  = 1'b0;
      out_ready = 1'b0;

      // Reset held two cycles with in_valid high
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_q",     32'(out_q),     32'h0);
      chk("rst_in_ready",  32'(in_ready),  32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'h1);
      step();

      // Shift variants
      run_op("lsr3",  8'hB4, 3'd3, 1'b0, 1'b0, 8'h16);
      run_op("asr3",  8'hB4, 3'd3, 1'b0, 1'b1, 8'hF6);
      run_op("lsl3",  8'hB4, 3'd3, 1'b1, 1'b1, 8'hA0);
      run_op("lsr7",  8'h81, 3'd7, 1'b0, 1'b0, 8'h01);
      run_op("lsl7",  8'h81, 3'd7, 1'b1, 1'b0, 8'h80);
      run_op("asr7",  8'h81, 3'd7, 1'b0, 1'b1, 8'hFF);
      run_op("zero",  8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A);

      // Backpressure: result 0x16 held while new requests are offered
      in_valid = 1'b1;
      in_d     = 8'hB4;
      in_amt   = 3'd3;
      in_dir   = 1'b0;
      in_arith = 1'b0;
      step();
      in_d = 8'hFF;
      in_amt = 3'd1;
      step();
      step();
      step();                       // edge t+3: DONE entered
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid",   32'(out_valid), 32'h1);
         chk("bp_q",       32'(out_q),     32'h16);
         chk("bp_inready", 32'(in_ready),  32'h0);
         step();
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      step();
      out_ready = 1'b0;
      chk("bp_release_busy",  32'(busy),      32'h0);
      chk("bp_release_valid", 32'(out_valid), 32'h0);
      chk("bp_release_q",     32'(out_q),     32'h16);

      // Reset at the 3rd SHIFT edge of an amt=7 request
      in_valid = 1'b1;
      in_d     = 8'hB4;
      in_amt   = 3'd7;
      in_dir   = 1'b0;
      in_arith = 1'b0;
      step();                       // accept edge t
      in_valid = 1'b0;
      step();                       // t+1
      step();                       // t+2
      rst = 1'b0;
      step();                       // t+3 under reset
      chk("abort_busy",    32'(busy),      32'h0);
      chk("abort_valid",   32'(out_valid), 32'h0);
      chk("abort_q",       32'(out_q),     32'h0);
      chk("abort_inready", 32'(in_ready),  32'h0);
      rst = 1'b1;
      out_ready = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid === 1'b1) seen_valid = 1;
      end
      out_ready = 1'b0;
      chk("abort_no_result", 32'(seen_valid), 32'h0);
      chk("abort_idle",      32'(in_ready),   32'h1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
